// File: rtl/exec_unit_if.sv
// Issue and result bundle for exec_unit: operand/handshake signals towards the
// unit and the registered write-back/redirect signals coming out of it.
interface exec_unit_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 6
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             mul;
  logic             use_imm;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  rs1_v;
  logic [XLEN-1:0]  rs2_v;
  logic [XLEN-1:0]  imm;
  logic [REG_W-1:0] rd;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  data;
  logic             reg_write_enabled;
  logic [REG_W-1:0] reg_write_dest;
  logic             is_jump_enabled;
  logic [XLEN-1:0]  jump_dest;

  modport master (
    output flush, in_valid, op, mul, use_imm, pc, rs1_v, rs2_v, imm, rd, out_ready,
    input  in_ready, out_valid, data, reg_write_enabled, reg_write_dest,
           is_jump_enabled, jump_dest
  );

  modport slave (
    input  flush, in_valid, op, mul, use_imm, pc, rs1_v, rs2_v, imm, rd, out_ready,
    output in_ready, out_valid, data, reg_write_enabled, reg_write_dest,
           is_jump_enabled, jump_dest
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU/branch/jump with registered results, plus an
// iterative LSB-first shift-add multiplier, valid/ready on both sides and flush.
module exec_unit #(
  parameter int XLEN  = 32,
  parameter int REG_W = 6
) (
  input  logic         clk,
  input  logic         rstn,
  exec_unit_if.slave   bus
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_BEQ  = 4'd10, OP_BNE  = 4'd11,
    OP_BLT  = 4'd12, OP_BGE  = 4'd13, OP_JAL  = 4'd14, OP_JALR = 4'd15
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_e;

  state_e          state;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [SHW-1:0]  cnt;

  logic [XLEN-1:0] opb;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] res_data;
  logic            res_load_data;
  logic            res_wen;
  logic            res_jen;
  logic [XLEN-1:0] res_jdest;
  logic [XLEN-1:0] acc_next;
  logic [XLEN-1:0] jalr_sum;
  logic            accept;

  // in_ready is held low while rstn is asserted, not just after the first edge.
  assign bus.in_ready = rstn && !bus.flush &&
                        (state == S_IDLE || (state == S_HOLD && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  assign opb      = bus.use_imm ? bus.imm : bus.rs2_v;
  assign shamt    = opb[SHW-1:0];
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign jalr_sum = bus.rs1_v + bus.imm;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    res_data      = '0;
    res_load_data = 1'b1;
    res_wen       = (bus.rd != '0);
    res_jen       = 1'b0;
    res_jdest     = bus.pc + bus.imm;
    case (op_e'(bus.op))
      OP_ADD:  res_data = bus.rs1_v + opb;
      OP_SUB:  res_data = bus.rs1_v - opb;
      OP_AND:  res_data = bus.rs1_v & opb;
      OP_OR:   res_data = bus.rs1_v | opb;
      OP_XOR:  res_data = bus.rs1_v ^ opb;
      OP_SLL:  res_data = bus.rs1_v << shamt;
      OP_SRL:  res_data = bus.rs1_v >> shamt;
      OP_SRA:  res_data = XLEN'($signed(bus.rs1_v) >>> shamt);
      OP_SLT:  res_data = {{(XLEN-1){1'b0}}, $signed(bus.rs1_v) < $signed(opb)};
      OP_SLTU: res_data = {{(XLEN-1){1'b0}}, bus.rs1_v < opb};
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE: begin
        // Branches leave data untouched and never write back.
        res_load_data = 1'b0;
        res_wen       = 1'b0;
        case (op_e'(bus.op))
          OP_BEQ:  res_jen = (bus.rs1_v == bus.rs2_v);
          OP_BNE:  res_jen = (bus.rs1_v != bus.rs2_v);
          OP_BLT:  res_jen = ($signed(bus.rs1_v) <  $signed(bus.rs2_v));
          default: res_jen = ($signed(bus.rs1_v) >= $signed(bus.rs2_v));
        endcase
      end
      OP_JAL: begin
        res_data = bus.pc + XLEN'(4);
        res_jen  = 1'b1;
      end
      default: begin
        res_data  = bus.pc + XLEN'(4);
        res_jen   = 1'b1;
        res_jdest = {jalr_sum[XLEN-1:1], 1'b0};
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                 <= S_IDLE;
      bus.out_valid         <= 1'b0;
      bus.data              <= '0;
      bus.reg_write_enabled <= 1'b0;
      bus.reg_write_dest    <= '0;
      bus.is_jump_enabled   <= 1'b0;
      bus.jump_dest         <= '0;
      mcand                 <= '0;
      mplier                <= '0;
      acc                   <= '0;
      cnt                   <= '0;
    end else if (bus.flush) begin
      state         <= S_IDLE;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (accept) begin
            bus.reg_write_dest <= bus.rd;
            if (bus.mul) begin
              state                 <= S_MUL;
              bus.out_valid         <= 1'b0;
              bus.reg_write_enabled <= (bus.rd != '0);
              bus.is_jump_enabled   <= 1'b0;
              mcand                 <= bus.rs1_v;
              mplier                <= opb;
              acc                   <= '0;
              cnt                   <= '0;
            end else begin
              state                 <= S_HOLD;
              bus.out_valid         <= 1'b1;
              bus.reg_write_enabled <= res_wen;
              bus.is_jump_enabled   <= res_jen;
              if (res_load_data) bus.data      <= res_data;
              if (res_jen)       bus.jump_dest <= res_jdest;
            end
          end else if (state == S_HOLD && bus.out_ready) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == SHW'(XLEN - 1)) begin
            state         <= S_HOLD;
            bus.out_valid <= 1'b1;
            bus.data      <= acc_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised, handshaked execute stage for the RV32-style core. It sits between decode/register-read and write-back. Single-cycle ALU, branch and jump operations are registered with one cycle of latency. An iterative shift-add multiplier runs for several cycles, with valid/ready back-pressure on both sides and a synchronous flush for branch recovery.

## Interface
- XLEN, 32: datapath width; must be a power of two, ≥ 8.
- REG_W, 6: register-destination index width.
- clk  in  1: clock, rising edge.
- rstn  in  1: asynchronous active-low reset.
- flush  in  1: synchronous kill of the in-flight and held result.
- in_valid  in  1: operation presented.
- in_ready  out  1: unit can accept this cycle.
- op  in  4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 JAL, 15 JALR; MUL is selected by mul=1.
- mul  in  1: when 1, op is ignored and the multiply (low XLEN bits of rs1_v·b) runs.
- use_imm  in  1: operand b = imm; otherwise b = rs2_v (ALU ops only).
- pc, rs1_v, rs2_v, imm  in  XLEN each: operands.
- rd  in  REG_W: destination index.
- out_valid  out  1: result registers hold a valid result.
- out_ready  in  1: consumer takes the result.
- data  out  XLEN: write-back value.
- reg_write_enabled  out  1: write-back requested.
- reg_write_dest  out  REG_W: write-back index.
- is_jump_enabled  out  1: redirect taken.
- jump_dest  out  XLEN: redirect target.

## Operation
- States: IDLE, MUL, HOLD.
  - IDLE→HOLD on an accepted single-cycle op.
  - IDLE→MUL on an accepted mul.
  - MUL→HOLD after XLEN iterations.
  - HOLD→IDLE when out_ready and no new accept.
  - HOLD→HOLD when out_ready and a new single-cycle op is accepted the same cycle.
  - HOLD→MUL when out_ready and a mul is accepted the same cycle.
- in_ready = !flush && (state==IDLE || (state==HOLD && out_ready)).
- Accept = in_valid && in_ready. Operands, rd and op are captured on accept. Inputs are don't-care otherwise.
- ALU results:
  - ADD/SUB wrap modulo 2^XLEN.
  - Shifts use b[log2(XLEN)-1:0]. SRA is arithmetic.
  - SLT is signed, SLTU unsigned; both give 0 or 1 zero-extended.
- Branches compare rs1_v with rs2_v (BLT/BGE signed).
  - Taken: is_jump_enabled=1, jump_dest=pc+imm.
  - Not taken: is_jump_enabled=0.
  - Branches never write a register.
- JAL: data=pc+4, jump_dest=pc+imm, is_jump_enabled=1.
- JALR: data=pc+4, jump_dest=(rs1_v+imm) with bit 0 cleared, is_jump_enabled=1.
- Register write: reg_write_enabled=1 for ALU ops, JAL, JALR and MUL, but forced to 0 when rd==0. reg_write_dest=rd always.
- MUL: shift-add, one multiplier bit per cycle, LSB first, XLEN cycles in MUL. The product is truncated to XLEN bits; signedness is irrelevant for the low half.
- For non-jump results, is_jump_enabled=0 and jump_dest is held at its previous value.
- flush (highest priority):
  - out_valid←0, state←IDLE, any MUL abandoned.
  - No accept occurs in the flush cycle.

## Timing
- Reset (rstn low, asynchronous):
  - state=IDLE; out_valid, reg_write_enabled, is_jump_enabled = 0.
  - data, jump_dest = 0; reg_write_dest = 0.
  - in_ready = 0 while in reset, then follows the rule above.
- Single-cycle op accepted at edge N → out_valid=1 with results after edge N; visible during cycle N+1.
- MUL accepted at edge N → out_valid=1 after edge N+XLEN. in_ready=0 throughout MUL.
- Results stay stable while out_valid && !out_ready.
- Throughput: one single-cycle op per cycle while out_ready=1.
- Reset mid-MUL: partial product is discarded; no output is produced.
- flush in the same cycle as out_ready: the result is treated as consumed-and-dropped; out_valid=0 next cycle.

## Test plan
- Reset, then ADD with use_imm=1, rs1_v=5, imm=0xFFFFFFFF, rd=3 → next cycle out_valid=1, data=4, reg_write_enabled=1, reg_write_dest=3, is_jump_enabled=0.
- BEQ pc=0x100, rs1_v=rs2_v=7, imm=0x20 → is_jump_enabled=1, jump_dest=0x120, reg_write_enabled=0. Repeat with rs2_v=8 → is_jump_enabled=0.
- JALR rd=0, pc=0x40, rs1_v=0x1001, imm=2 → data=0x44, jump_dest=0x1002, reg_write_enabled=0.
- MUL rs1_v=0xFFFFFFFF, rs2_v=3, XLEN=32 → in_ready=0 for 32 cycles, then out_valid=1, data=0xFFFFFFFD.
- Back-to-back stream with out_ready held low for 3 cycles → output stable, in_ready=0, no op lost or duplicated after out_ready rises.
- flush at cycle 10 of a MUL, plus SRA 0x80000000>>4 at XLEN=16 instance (rs1_v=0x8000) → after flush out_valid stays 0 and state is IDLE; SRA yields 0xF800.
